segmented_display_decoder: RTL and testbench

//  Receiving end of the multiplexed segmented-display interface. It samples the anode and cathode

---
 rtl/segmented_display_decoder.sv | 203 ++++++++++++++++++++
 tb/tb_segmented_display_decoder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/segmented_display_decoder.sv
// segmented_display_decoder
//   Receiving end of a multiplexed seven/eight-segment display interface. It
//   watches the anode (digit select) and cathode (segment) lines of a scanned
//   display and recovers the hex nybble shown on each digit. It is used as a
//   loopback monitor for a display driver.
//
// Ports
//   clock        system clock, all logic on the rising edge
//   reset        synchronous, active-high
//   anode        digit selects, bit 0 = least significant digit
//   cathode      segments {a,b,c,d,e,f,g[,dp]}, a = MSB, dp ignored
//   data         recovered nybbles, [3:0] = digit 0
//   digit_valid  bit k set when nybble k holds a decoded pattern
//   frame_strobe one-cycle pulse once every digit has been captured
//   error        one-cycle pulse on an undecodable pattern or several anodes
module segmented_display_decoder #(
  parameter int number_of_segments = 8,
  parameter int number_of_nybbles  = 4,
  parameter int settle_cycles      = 16,
  parameter bit anode_active_high  = 1'b1,
  parameter bit cathode_active_low = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [number_of_nybbles-1:0]   anode,
  input  logic [number_of_segments-1:0]  cathode,
  output logic [4*number_of_nybbles-1:0] data,
  output logic [number_of_nybbles-1:0]   digit_valid,
  output logic                           frame_strobe,
  output logic                           error
);

  localparam int N  = number_of_nybbles;
  localparam int S  = number_of_segments;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] settle_limit = 8'(settle_cycles);

  // Pin levels that mean "nothing selected / nothing lit"
  localparam logic [N-1:0] anode_idle   = anode_active_high  ? '0 : '1;
  localparam logic [S-1:0] cathode_idle = cathode_active_low ? '1 : '0;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  logic [N-1:0]  anode_meta, anode_sync;
  logic [S-1:0]  cathode_meta, cathode_sync;
  logic [N-1:0]  anode_norm, anode_prev;
  logic [S-1:0]  cathode_norm, cathode_prev;
  logic [6:0]    segments;
  logic [7:0]    stable_count;
  logic          changed, multi, one_hot, anode_zero, settled;

  state_t        state;
  logic [N-1:0]  cap_anode;
  logic [6:0]    cap_segments;
  logic [IW-1:0] cap_index;
  logic [4:0]    cap_decode;
  logic [N-1:0]  seen;
  logic          multi_q;

  // Two-flop synchronisers. They reset to the idle pin level so that an
  // inverted-polarity configuration does not see every anode selected
  // straight out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      anode_meta   <= anode_idle;
      anode_sync   <= anode_idle;
      cathode_meta <= cathode_idle;
      cathode_sync <= cathode_idle;
    end else begin
      anode_meta   <= anode;
      anode_sync   <= anode_meta;
      cathode_meta <= cathode;
      cathode_sync <= cathode_meta;
    end
  end

  // After normalisation 1 always means selected / lit
  assign anode_norm   = anode_active_high  ? anode_sync   : ~anode_sync;
  assign cathode_norm = cathode_active_low ? ~cathode_sync : cathode_sync;
  assign segments     = cathode_norm[S-1 -: 7];

  assign changed    = {anode_norm, cathode_norm} != {anode_prev, cathode_prev};
  assign anode_zero = (anode_norm == '0);
  // Clearing the lowest set bit leaves something only if two or more are set
  assign multi      = (anode_norm & (anode_norm - N'(1))) != '0;
  assign one_hot    = !anode_zero && !multi;
  assign settled    = !changed && (stable_count == settle_limit);

  // Stable counter: counts consecutive identical samples of the pair,
  // saturating once the settle time has been reached.
  always_ff @(posedge clock) begin
    if (reset) begin
      anode_prev   <= '0;
      cathode_prev <= '0;
      stable_count <= '0;
    end else begin
      anode_prev   <= anode_norm;
      cathode_prev <= cathode_norm;
      if (changed)
        stable_count <= '0;
      else if (stable_count < settle_limit)
        stable_count <= stable_count + 8'd1;
    end
  end

  // Convert the latched one-hot anode to a digit index
  always_comb begin
    cap_index = '0;
    for (int i = 0; i < N; i++)
      if (cap_anode[i]) cap_index = IW'(i);
  end

  // Segment pattern {a..g} to {valid, nybble}
  function automatic logic [4:0] decode_segments(input logic [6:0] seg);
    case (seg)
      7'h7E: return {1'b1, 4'h0};
      7'h30: return {1'b1, 4'h1};
      7'h6D: return {1'b1, 4'h2};
      7'h79: return {1'b1, 4'h3};
      7'h33: return {1'b1, 4'h4};
      7'h5B: return {1'b1, 4'h5};
      7'h5F: return {1'b1, 4'h6};
      7'h70: return {1'b1, 4'h7};
      7'h7F: return {1'b1, 4'h8};
      7'h7B: return {1'b1, 4'h9};
      7'h77: return {1'b1, 4'hA};
      7'h1F: return {1'b1, 4'hB};
      7'h4E: return {1'b1, 4'hC};
      7'h3D: return {1'b1, 4'hD};
      7'h4F: return {1'b1, 4'hE};
      7'h47: return {1'b1, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  assign cap_decode = decode_segments(cap_segments);

  // Capture FSM with registered outputs. Several active anodes override
  // everything: the FSM parks in IDLE and the error pulses only on the
  // first cycle of the condition. The pair is latched on entry to CAPTURE
  // so the decode works on exactly the value that was judged stable.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cap_anode    <= '0;
      cap_segments <= '0;
      seen         <= '0;
      multi_q      <= 1'b0;
      data         <= '0;
      digit_valid  <= '0;
      frame_strobe <= 1'b0;
      error        <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      error        <= 1'b0;
      multi_q      <= multi;
      if (multi) begin
        state <= IDLE;
        error <= !multi_q;
      end else begin
        case (state)
          IDLE: begin
            if (one_hot) state <= SETTLE;
          end
          SETTLE: begin
            if (anode_zero) begin
              state <= IDLE;
            end else if (settled) begin
              state        <= CAPTURE;
              cap_anode    <= anode_norm;
              cap_segments <= segments;
            end
          end
          CAPTURE: begin
            if (cap_decode[4]) begin
              data[cap_index*4 +: 4] <= cap_decode[3:0];
              digit_valid[cap_index] <= 1'b1;
              if ((seen | cap_anode) == '1) begin
                seen         <= '0;
                frame_strobe <= 1'b1;
              end else begin
                seen <= seen | cap_anode;
              end
            end else begin
              error                  <= 1'b1;
              digit_valid[cap_index] <= 1'b0;
            end
            // A change landing during the capture cycle must not be lost
            if (changed)
              state <= anode_zero ? IDLE : SETTLE;
            else
              state <= HOLD;
          end
          HOLD: begin
            if (changed) state <= anode_zero ? IDLE : SETTLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_segmented_display_decoder.sv
// Testbench for segmented_display_decoder. A default-polarity instance is
// exercised with directed slots and random slots; a second instance with
// both polarities inverted decodes the full code table on digit 3.
module tb_segmented_display_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  anode, anode_inv;
  logic [7:0]  cathode, cathode_inv;
  logic [15:0] data, data_inv;
  logic [3:0]  digit_valid, digit_valid_inv;
  logic        frame_strobe, error, frame_strobe_inv, error_inv;

  always #5 clock = ~clock;

  segmented_display_decoder dut (
    .clock(clock), .reset(reset), .anode(anode), .cathode(cathode),
    .data(data), .digit_valid(digit_valid),
    .frame_strobe(frame_strobe), .error(error)
  );

  segmented_display_decoder #(
    .anode_active_high(1'b0), .cathode_active_low(1'b0)
  ) dut_inv (
    .clock(clock), .reset(reset), .anode(anode_inv), .cathode(cathode_inv),
    .data(data_inv), .digit_valid(digit_valid_inv),
    .frame_strobe(frame_strobe_inv), .error(error_inv)
  );

  int checks = 0;
  int failures = 0;
  int strobe_seen = 0, error_seen = 0;
  int strobe_inv_seen = 0, error_inv_seen = 0;

  // Reference model state: per-digit nybbles plus frame bookkeeping
  logic [3:0] ref_nybble [4];
  logic [3:0] ref_valid, ref_seen;
  int ref_strobes = 0, ref_errors = 0;

  logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Pulse counters, sampled mid-cycle
  always @(negedge clock) begin
    if (frame_strobe)     strobe_seen++;
    if (error)            error_seen++;
    if (frame_strobe_inv) strobe_inv_seen++;
    if (error_inv)        error_inv_seen++;
  end

  function automatic int lookupCode(input logic [6:0] pat);
    for (int i = 0; i < 16; i++)
      if (codes[i] == pat) return i;
    return -1;
  endfunction

  function automatic logic [15:0] expectedData();
    return {ref_nybble[3], ref_nybble[2], ref_nybble[1], ref_nybble[0]};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) ref_nybble[i] = 4'h0;
    ref_valid = 4'h0;
    ref_seen  = 4'h0;
  endtask

  // Effect of one display slot that was held long enough to be captured
  task automatic modelSlot(input logic [3:0] an, input logic [6:0] pat);
    int k, v;
    k = 0;
    if (an == 4'h0) return;
    if ($countones(an) > 1) begin
      ref_errors++;
      return;
    end
    for (int i = 0; i < 4; i++) if (an[i]) k = i;
    v = lookupCode(pat);
    if (v < 0) begin
      ref_errors++;
      ref_valid[k] = 1'b0;
    end else begin
      ref_nybble[k] = v[3:0];
      ref_valid[k]  = 1'b1;
      ref_seen[k]   = 1'b1;
      if (ref_seen == 4'hF) begin
        ref_strobes++;
        ref_seen = 4'h0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_data"}, 32'(data), 32'(expectedData()));
    checkOutput({tag, "_valid"}, 32'(digit_valid), 32'(ref_valid));
    checkOutput({tag, "_strobes"}, strobe_seen, ref_strobes);
    checkOutput({tag, "_errors"}, error_seen, ref_errors);
  endtask

  // Drive the default instance's pins (active-high anode, active-low cathode)
  task automatic drivePins(input logic [3:0] an, input logic [6:0] pat, input int cycles);
    logic dp;
    dp = 1'($urandom_range(0, 1));
    anode   = an;
    cathode = ~{pat, dp};
    repeat (cycles) @(negedge clock);
  endtask

  // One display slot followed by a short blank gap
  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] pat, input int hold);
    drivePins(an, pat, hold);
    drivePins(4'h0, 7'h00, 4);
    modelSlot(an, pat);
  endtask

  initial begin
    reset       = 1'b1;
    anode       = 4'h0;
    cathode     = 8'hFF;
    anode_inv   = 4'hF;
    cathode_inv = 8'h00;
    modelReset();
    repeat (3) @(negedge clock);
    checkOutput("reset_data", 32'(data), 0);
    checkOutput("reset_valid", 32'(digit_valid), 0);
    checkOutput("reset_strobe", 32'(frame_strobe), 0);
    checkOutput("reset_error", 32'(error), 0);
    checkOutput("reset_inv_data", 32'(data_inv), 0);
    reset = 1'b0;

    // Two scans of 16'h1122
    for (int scan = 0; scan < 2; scan++) begin
      applyStimulus(4'b0001, codes[2], 30);
      applyStimulus(4'b0010, codes[2], 30);
      applyStimulus(4'b0100, codes[1], 30);
      applyStimulus(4'b1000, codes[1], 30);
      checkState("scan1122");
    end
    checkOutput("scan1122_value", 32'(data), 32'h1122);
    checkOutput("scan1122_strobes", strobe_seen, 2);

    // Slot shorter than the settle time: no capture
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    drivePins(4'b0001, 7'h5B, 15);
    drivePins(4'h0, 7'h00, 30);
    checkOutput("short_data", 32'(data), 0);
    checkOutput("short_valid", 32'(digit_valid), 0);
    checkState("short");

    // Blank pattern on digit 2 after a good capture there
    applyStimulus(4'b0100, codes[9], 30);
    applyStimulus(4'b0100, 7'h00, 40);
    checkState("blank");
    checkOutput("blank_nybble", 32'(data[11:8]), 9);
    checkOutput("blank_valid2", 32'(digit_valid[2]), 0);

    // Two anodes at once, then straight back to one-hot
    drivePins(4'b0011, codes[5], 20);
    modelSlot(4'b0011, codes[5]);
    checkState("multi");
    applyStimulus(4'b0001, codes[14], 30);
    checkState("resume");

    // Reset in the middle of settling digit 3 after digits 0..2
    applyStimulus(4'b0001, codes[3], 30);
    applyStimulus(4'b0010, codes[4], 30);
    applyStimulus(4'b0100, codes[5], 30);
    checkState("pre_reset");
    drivePins(4'b1000, codes[6], 8);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_data", 32'(data), 0);
    checkOutput("midreset_valid", 32'(digit_valid), 0);
    checkOutput("midreset_strobe", 32'(frame_strobe), 0);
    checkOutput("midreset_error", 32'(error), 0);
    reset = 1'b0;
    modelReset();
    applyStimulus(4'b1000, codes[6], 30);
    checkState("post_reset_d3");
    applyStimulus(4'b0001, codes[7], 30);
    applyStimulus(4'b0010, codes[8], 30);
    checkState("post_reset_d01");
    applyStimulus(4'b0100, codes[10], 30);
    checkState("post_reset_frame");

    // Inverted polarities: every code on digit 3
    for (int v = 0; v < 16; v++) begin
      anode_inv   = ~4'b1000;
      cathode_inv = {codes[v], 1'b0};
      repeat (30) @(negedge clock);
      anode_inv   = 4'hF;
      cathode_inv = 8'h00;
      repeat (4) @(negedge clock);
      checkOutput("inv_nybble", 32'(data_inv[15:12]), v);
    end
    checkOutput("inv_valid", 32'(digit_valid_inv), 32'h8);
    checkOutput("inv_errors", error_inv_seen, 0);
    checkOutput("inv_strobes", strobe_inv_seen, 0);

    // Random slots: mostly valid codes, some invalid patterns, some multi-anode
    for (int s = 0; s < 40; s++) begin
      int r, a, b;
      logic [3:0] an;
      logic [6:0] pat;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        a   = $urandom_range(0, 3);
        b   = (a + 1 + $urandom_range(0, 2)) % 4;
        an  = 4'((1 << a) | (1 << b));
        pat = codes[$urandom_range(0, 15)];
      end else begin
        an = 4'(1 << $urandom_range(0, 3));
        if (r == 1) begin
          do pat = 7'($urandom_range(0, 127)); while (lookupCode(pat) >= 0);
        end else begin
          pat = codes[$urandom_range(0, 15)];
        end
      end
      applyStimulus(an, pat, $urandom_range(24, 40));
      checkState("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
